// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: issues loads/stores on a req/gnt/rvalid port, stalls upstream
// until the access completes, and registers the MEM/WB result.
module mem_stage_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic                      MemRead_i,
  input  logic                      MemWrite_i,
  input  logic                      RegWrite_i,
  input  logic [2:0]                funct3_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                      stall_o,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [DATA_WIDTH-1:0]     dmem_addr_o,
  output logic [3:0]                dmem_be_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic                      wb_valid_o,
  output logic                      wb_RegWrite_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      misalign_exc_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t                    state_reg, state_next;
  logic                      dmem_req_reg, dmem_req_next;
  logic                      dmem_we_reg, dmem_we_next;
  logic [DATA_WIDTH-1:0]     dmem_addr_reg, dmem_addr_next;
  logic [3:0]                dmem_be_reg, dmem_be_next;
  logic [DATA_WIDTH-1:0]     dmem_wdata_reg, dmem_wdata_next;
  logic [2:0]                funct3_reg, funct3_next;
  logic [1:0]                addr_lo_reg, addr_lo_next;
  logic [REG_ADDR_WIDTH-1:0] rd_reg, rd_next;
  logic                      regwrite_reg, regwrite_next;
  logic                      wb_valid_reg, wb_valid_next;
  logic                      wb_regwrite_reg, wb_regwrite_next;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_reg, wb_rd_next;
  logic [DATA_WIDTH-1:0]     wb_data_reg, wb_data_next;
  logic                      misalign_reg, misalign_next;

  logic                  mem_op, is_store, size_ok, misaligned, access_bad;
  logic [3:0]            store_be;
  logic [DATA_WIDTH-1:0] store_wdata, load_shifted, load_data;

  assign mem_op   = valid_i & (MemRead_i | MemWrite_i);
  assign is_store = MemWrite_i & ~MemRead_i;

  always_comb begin
    if (is_store)
      size_ok = (funct3_i == 3'b000) | (funct3_i == 3'b001) | (funct3_i == 3'b010);
    else
      size_ok = (funct3_i == 3'b000) | (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                (funct3_i == 3'b100) | (funct3_i == 3'b101);
  end

  assign misaligned = ((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                      ((funct3_i[1:0] == 2'b10) & (alu_result_i[1:0] != 2'b00));
  assign access_bad = ~size_ok | misaligned;

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   store_be = 4'b0001 << alu_result_i[1:0];
      2'b01:   store_be = 4'b0011 << alu_result_i[1:0];
      default: store_be = 4'b1111;
    endcase
  end

  // Replicate the store operand so every enabled lane already carries the right byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_store_lane
      assign store_wdata[8*gi +: 8] =
        (funct3_i[1:0] == 2'b00) ? rs2_data_i[7:0] :
        (funct3_i[1:0] == 2'b01) ? rs2_data_i[8*(gi%2) +: 8] :
                                   rs2_data_i[8*gi +: 8];
    end
  endgenerate

  assign load_shifted = dmem_rdata_i >> {addr_lo_reg, 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  load_data = {{(DATA_WIDTH-8){load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_shifted[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_shifted[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    stall_o          = 1'b0;
    dmem_req_next    = dmem_req_reg;
    dmem_we_next     = dmem_we_reg;
    dmem_addr_next   = dmem_addr_reg;
    dmem_be_next     = dmem_be_reg;
    dmem_wdata_next  = dmem_wdata_reg;
    funct3_next      = funct3_reg;
    addr_lo_next     = addr_lo_reg;
    rd_next          = rd_reg;
    regwrite_next    = regwrite_reg;
    wb_valid_next    = 1'b0;
    wb_regwrite_next = wb_regwrite_reg;
    wb_rd_next       = wb_rd_reg;
    wb_data_next     = wb_data_reg;
    misalign_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_i && !mem_op) begin
          wb_valid_next    = 1'b1;
          wb_regwrite_next = RegWrite_i;
          wb_rd_next       = rd_addr_i;
          wb_data_next     = alu_result_i;
        end else if (mem_op && access_bad) begin
          wb_valid_next    = 1'b1;
          wb_regwrite_next = 1'b0;
          wb_rd_next       = rd_addr_i;
          misalign_next    = 1'b1;
        end else if (mem_op) begin
          stall_o         = 1'b1;
          state_next      = REQ;
          dmem_req_next   = 1'b1;
          dmem_we_next    = is_store;
          dmem_addr_next  = {alu_result_i[DATA_WIDTH-1:2], 2'b00};
          dmem_be_next    = is_store ? store_be : 4'b1111;
          dmem_wdata_next = is_store ? store_wdata : '0;
          funct3_next     = funct3_i;
          addr_lo_next    = alu_result_i[1:0];
          rd_next         = rd_addr_i;
          regwrite_next   = RegWrite_i;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i) begin
          dmem_req_next = 1'b0;
          if (dmem_we_reg) begin
            // Store completes on grant, so upstream may advance this cycle.
            stall_o          = 1'b0;
            wb_valid_next    = 1'b1;
            wb_regwrite_next = 1'b0;
            wb_rd_next       = rd_reg;
            state_next       = IDLE;
          end else begin
            state_next = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        stall_o = ~dmem_rvalid_i;
        if (dmem_rvalid_i) begin
          wb_valid_next    = 1'b1;
          wb_regwrite_next = regwrite_reg;
          wb_rd_next       = rd_reg;
          wb_data_next     = load_data;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      dmem_req_reg    <= 1'b0;
      dmem_we_reg     <= 1'b0;
      dmem_addr_reg   <= '0;
      dmem_be_reg     <= '0;
      dmem_wdata_reg  <= '0;
      funct3_reg      <= '0;
      addr_lo_reg     <= '0;
      rd_reg          <= '0;
      regwrite_reg    <= 1'b0;
      wb_valid_reg    <= 1'b0;
      wb_regwrite_reg <= 1'b0;
      wb_rd_reg       <= '0;
      wb_data_reg     <= '0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      dmem_req_reg    <= dmem_req_next;
      dmem_we_reg     <= dmem_we_next;
      dmem_addr_reg   <= dmem_addr_next;
      dmem_be_reg     <= dmem_be_next;
      dmem_wdata_reg  <= dmem_wdata_next;
      funct3_reg      <= funct3_next;
      addr_lo_reg     <= addr_lo_next;
      rd_reg          <= rd_next;
      regwrite_reg    <= regwrite_next;
      wb_valid_reg    <= wb_valid_next;
      wb_regwrite_reg <= wb_regwrite_next;
      wb_rd_reg       <= wb_rd_next;
      wb_data_reg     <= wb_data_next;
      misalign_reg    <= misalign_next;
    end
  end

  assign dmem_req_o     = dmem_req_reg;
  assign dmem_we_o      = dmem_we_reg;
  assign dmem_addr_o    = dmem_addr_reg;
  assign dmem_be_o      = dmem_be_reg;
  assign dmem_wdata_o   = dmem_wdata_reg;
  assign wb_valid_o     = wb_valid_reg;
  assign wb_RegWrite_o  = wb_regwrite_reg;
  assign wb_rd_addr_o   = wb_rd_reg;
  assign wb_data_o      = wb_data_reg;
  assign misalign_exc_o = misalign_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a driver acts as upstream pipeline and data memory,
// a monitor checks every MEM/WB retirement against queued expectations.
module tb_mem_stage_lsu;

  logic        clk, rst;
  logic        valid_i, MemRead_i, MemWrite_i, RegWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_RegWrite_o, misalign_exc_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RegWrite_i(RegWrite_i), .funct3_i(funct3_i), .alu_result_i(alu_result_i),
    .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
    .misalign_exc_o(misalign_exc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
    logic        chk_data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   retire_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every wb_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid_o) begin
        retire_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_wb: got wb_valid=1 data=%h, expected no retirement", wb_data_o);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.name, "_regwrite"}, wb_RegWrite_o, e.rw);
          chk({e.name, "_exc"}, misalign_exc_o, e.exc);
          if (e.chk_data) begin
            chk({e.name, "_data"}, wb_data_o, e.data);
            chk({e.name, "_rd"}, wb_rd_addr_o, e.rd);
          end
        end
      end else if (misalign_exc_o) begin
        tests++;
        fails++;
        $display("FAIL stray_exc: got misalign_exc=1 without wb_valid, expected 0");
      end
    end
  end

  task automatic idle(input int n);
    valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one instruction, plays the memory side, and returns once it is accepted.
  task automatic issue(input string name, input logic mr, input logic mw, input logic rw,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [4:0] rd, input int gd, input int rvd,
                       input logic [31:0] rdata, input logic bad, input logic [31:0] exp_data,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    exp_t e;
    int   phase, n_req, n_wait, stalls, exp_stall;
    logic accepted, gave_gnt;
    logic mem;
    mem = mr | mw;
    e.name = name; e.rd = rd; e.data = exp_data; e.exc = 1'b0; e.chk_data = 1'b1; e.rw = rw;
    if (!mem) begin
      e.data = addr; exp_stall = 0;
    end else if (bad) begin
      e.rw = 1'b0; e.exc = 1'b1; e.chk_data = 1'b0; exp_stall = 0;
    end else if (mw) begin
      e.rw = 1'b0; e.chk_data = 1'b0; exp_stall = 1 + gd;
    end else begin
      exp_stall = 2 + gd + rvd;
    end
    sb_q.push_back(e);
    valid_i = 1'b1; MemRead_i = mr; MemWrite_i = mw; RegWrite_i = rw; funct3_i = f3;
    alu_result_i = addr; rs2_data_i = rs2; rd_addr_i = rd;
    phase = 0; n_req = 0; n_wait = 0; stalls = 0; accepted = 1'b0;
    for (int c = 0; c < 60 && !accepted; c++) begin
      gave_gnt = 1'b0;
      @(negedge clk);
      if (mem && !bad) begin
        if (phase == 0 && dmem_req_o) phase = 1;
        if (phase == 1) begin
          chk({name, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
          chk({name, "_we"}, dmem_we_o, mw);
          chk({name, "_be"}, dmem_be_o, exp_be);
          if (mw) chk({name, "_wdata"}, dmem_wdata_o, exp_wdata);
          if (n_req == gd) begin dmem_gnt_i = 1'b1; gave_gnt = 1'b1; end
          n_req++;
        end else if (phase == 2) begin
          chk({name, "_req_dropped"}, dmem_req_o, 1'b0);
          if (n_wait == rvd) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; end
          n_wait++;
        end
      end
      #1;
      if (stall_o) stalls++;
      else accepted = 1'b1;
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      if (gave_gnt && !mw) phase = 2;
    end
    valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    if (!accepted) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no acceptance in 60 cycles, expected completion", name);
    end else begin
      chk({name, "_stall_cycles"}, stalls, exp_stall);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 0; MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; funct3_i = 0;
    alu_result_i = 0; rs2_data_i = 0; rd_addr_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", dmem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_exc", misalign_exc_o, 0);
    rst = 1'b0;
    idle(2);

    // passthrough, stores, loads
    issue("add", 0, 0, 1, 3'b000, 32'h0000_1234, 0, 5'd5, 0, 0, 0, 0, 32'h1234, 0, 0);
    issue("sb", 0, 1, 0, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 2, 0, 0, 0, 0, 4'b1000, 32'hDDDD_DDDD);
    issue("lb", 1, 0, 1, 3'b000, 32'h0000_0202, 0, 5'd7, 0, 0, 32'h12F0_5678, 0, 32'hFFFF_FFF0, 4'b1111, 0);
    issue("lbu", 1, 0, 1, 3'b100, 32'h0000_0202, 0, 5'd8, 0, 0, 32'h12F0_5678, 0, 32'h0000_00F0, 4'b1111, 0);
    issue("lh", 1, 0, 1, 3'b001, 32'h0000_0202, 0, 5'd9, 0, 0, 32'h12F0_5678, 0, 32'h0000_12F0, 4'b1111, 0);
    issue("sh", 0, 1, 0, 3'b001, 32'h0000_0002, 32'h1122_3344, 5'd0, 0, 0, 0, 0, 0, 4'b1100, 32'h3344_3344);
    issue("sw", 0, 1, 0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1, 0, 0, 0, 0, 4'b1111, 32'hDEAD_BEEF);
    issue("lhu", 1, 0, 1, 3'b101, 32'h0000_0000, 0, 5'd11, 0, 2, 32'h8001_FFFE, 0, 32'h0000_FFFE, 4'b1111, 0);
    issue("lh_neg", 1, 0, 1, 3'b001, 32'h0000_0000, 0, 5'd12, 0, 0, 32'h8001_FFFE, 0, 32'hFFFF_FFFE, 4'b1111, 0);
    issue("lb_hi", 1, 0, 1, 3'b000, 32'h0000_0003, 0, 5'd13, 1, 0, 32'h8001_FFFE, 0, 32'hFFFF_FF80, 4'b1111, 0);

    // misaligned and illegal-size accesses
    issue("lw_mis", 1, 0, 1, 3'b010, 32'h0000_0006, 0, 5'd14, 0, 0, 0, 1, 0, 0, 0);
    chk("lw_mis_no_req", dmem_req_o, 0);
    issue("ld_ill", 1, 0, 1, 3'b011, 32'h0000_0000, 0, 5'd15, 0, 0, 0, 1, 0, 0, 0);
    issue("st_ill", 0, 1, 0, 3'b100, 32'h0000_0000, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0);
    issue("sh_mis", 0, 1, 0, 3'b001, 32'h0000_0001, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0);
    chk("sh_mis_no_req", dmem_req_o, 0);
    idle(1);

    // back-to-back load then ALU op
    issue("lw_b2b", 1, 0, 1, 3'b010, 32'h0000_0040, 0, 5'd9, 1, 1, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'b1111, 0);
    issue("add_b2b", 0, 0, 1, 3'b000, 32'h0000_0055, 0, 5'd10, 0, 0, 0, 0, 32'h55, 0, 0);
    idle(2);
    if (retire_cyc.size() >= 2)
      chk("b2b_gap", retire_cyc[retire_cyc.size()-1] - retire_cyc[retire_cyc.size()-2], 1);

    // reset while waiting for load data
    valid_i = 1; MemRead_i = 1; RegWrite_i = 1; funct3_i = 3'b010; alu_result_i = 32'h80; rd_addr_i = 5'd3;
    @(posedge clk); #1;
    @(negedge clk); dmem_gnt_i = 1'b1;
    @(posedge clk); #1; dmem_gnt_i = 1'b0;
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; MemRead_i = 1'b0;
    #1;
    chk("rstw_req", dmem_req_o, 0);
    chk("rstw_stall", stall_o, 0);
    chk("rstw_wb_valid", wb_valid_o, 0);
    chk("rstw_wb_data", wb_data_o, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    #1; chk("rstw_stall_rvalid", stall_o, 0);
    @(posedge clk); #1; dmem_rvalid_i = 1'b0;
    chk("rstw_no_wb", wb_valid_o, 0);
    idle(2);

    // reset while the request is outstanding
    valid_i = 1; MemRead_i = 1; funct3_i = 3'b010; alu_result_i = 32'h84; rd_addr_i = 5'd4;
    @(posedge clk); #1;
    chk("rstr_req_before", dmem_req_o, 1);
    #2; rst = 1'b1; valid_i = 1'b0; MemRead_i = 1'b0;
    #1; chk("rstr_req_async", dmem_req_o, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(3);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory stage of the 5-stage RV32I pipeline. Consumes the EX/MEM pipeline-register outputs and runs loads and stores on a req/gnt/rvalid data-memory port. Produces registered MEM/WB results.
- Non-memory instructions pass through in 1 cycle.
- Memory instructions stall upstream via stall_o until the memory transaction completes.

Parameters:
DATA_WIDTH, 32, datapath and address width
REG_ADDR_WIDTH, 5, register-file index width

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_i  in  1  EX/MEM holds a valid instruction
MemRead_i  in  1  instruction is a load
MemWrite_i  in  1  instruction is a store
RegWrite_i  in  1  instruction writes rd
funct3_i  in  3  load/store size and sign
alu_result_i  in  DATA_WIDTH  effective address, or ALU result for non-memory ops
rs2_data_i  in  DATA_WIDTH  store data
rd_addr_i  in  REG_ADDR_WIDTH  destination register
stall_o  out  1  hold IF/ID/EX and the EX/MEM register
dmem_req_o  out  1  request valid, registered
dmem_we_o  out  1  1 = store
dmem_addr_o  out  DATA_WIDTH  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  DATA_WIDTH  lane-shifted store data
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  DATA_WIDTH  load data word
wb_valid_o  out  1  MEM/WB entry valid
wb_RegWrite_o  out  1  write rd in WB
wb_rd_addr_o  out  REG_ADDR_WIDTH  destination register
wb_data_o  out  DATA_WIDTH  load result or ALU result
misalign_exc_o  out  1  1-cycle pulse: misaligned or illegal-size access

Behaviour:
Reset:
- rst asserted (asynchronously) → state IDLE; every registered output is 0.
- dmem_req_o drops immediately, even mid-transaction.
- Any in-flight rvalid after reset release is ignored.

Definitions:
- mem_op = valid_i & (MemRead_i | MemWrite_i).
- Illegal size: funct3 ∉ {000, 001, 010, 100, 101} for loads; funct3 ∉ {000, 001, 010} for stores.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] ≠ 0.

FSM states: IDLE, REQ, WAIT_R.

IDLE:
- Non-mem valid op: next edge sets wb_valid_o = 1, wb_data_o = alu_result_i, and copies RegWrite and rd. stall_o = 0.
- mem_op that is misaligned or illegal: no request is issued. Next edge sets wb_valid_o = 1, wb_RegWrite_o = 0, misalign_exc_o = 1. stall_o = 0.
- Legal mem_op: stall_o = 1 (combinational). Latch the dmem_* fields, funct3, addr[1:0] and rd. Go to REQ. dmem_req_o = 1 from the next cycle.
- valid_i = 0: wb_valid_o = 0.

REQ:
- dmem_req_o and all dmem_* fields are held stable until gnt.
- gnt on a store: stall_o = 0 this cycle. Next edge: wb_valid_o = 1, wb_RegWrite_o = 0, go to IDLE.
- gnt on a load: go to WAIT_R; stall_o stays 1.
- No gnt: remain in REQ; stall_o = 1.
- At the edge after gnt, dmem_req_o drops.

WAIT_R:
- stall_o = ~dmem_rvalid_i.
- On rvalid: byte/halfword extracted by latched addr[1:0], then sign-extended (LB, LH) or zero-extended (LBU, LHU); LW passes the word. Next edge: wb_valid_o = 1, wb_RegWrite_o = latched RegWrite, go to IDLE.
- rvalid in the same cycle as gnt is not supported; the memory gives rvalid ≥ 1 cycle after gnt.

Stores:
- SB: be = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
- SH: be = 0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
- SW: be = 1111; wdata = rs2.
- Loads drive be = 1111 and we = 0.

Latency and pulses:
- Latency: non-mem 1 cycle. Memory op = 1 + grant wait + (load only) data wait; minimum store 2 cycles, minimum load 3 cycles.
- wb_valid_o and misalign_exc_o are 1-cycle pulses per instruction; the same instruction is never retired twice.
- dmem_rvalid_i outside WAIT_R is ignored.

Test Plan:
1. ADD passthrough: valid_i = 1, no mem, alu_result = 0x0000_1234, rd = 5 → next cycle wb_valid = 1, wb_data = 0x1234, wb_rd = 5, stall_o never asserted.
2. SB at addr 0x103, rs2 = 0xAABBCCDD, gnt after 2 cycles of REQ → dmem_addr = 0x100, be = 1000, wdata = 0xDDDDDDDD, stable across the wait; stall_o high 3 cycles; one wb_valid with RegWrite = 0.
3. LB at addr 0x202, rdata = 0x12F0_5678 → wb_data = 0xFFFF_FFF0. Same access as LBU → 0x0000_00F0. LH at 0x202 → 0x0000_12F0.
4. LW at addr 0x006 → no dmem_req_o, misalign_exc_o = 1 for 1 cycle, wb_RegWrite = 0, stall_o = 0.
5. Reset mid-load: assert rst while in WAIT_R → dmem_req_o, stall_o (from the state), and wb_* go 0 asynchronously; a later rvalid produces no wb_valid.
6. Back-to-back LW then ADD with gnt and rvalid each 1 cycle late → ADD is held by stall_o and retires exactly one cycle after the LW's wb_valid.
